pkt_rr_arbiter: RTL and testbench
=================================

# pkt_rr_arbiter

Round-robin output-port arbiter for the five-port (L, N, E, W, S) NoC router. It grants one input port at a time to a shared output channel. A grant is won only on a header flit and is held until that packet's tail flit transfers, so packets are never interleaved. It replaces the fixed-priority, length-timer scheme with fair rotation plus an optional stall watchdog, and sits between the input buffers and the output crossbar mux.

## Interface
Parameters:
- NPORT, 5, number of requesters; index 0..4 = L, N, E, W, S.
- TIMEOUT, 255, stall cycles tolerated while locked before forced release (watchdog build only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NPORT  per-port flit valid.
- flit_id  in  3*NPORT  per-port flit type, port i at [3i+2:3i]; 3'b001 header, 3'b010 body, 3'b100 tail.
- out_ready  in  1  downstream channel can accept a flit this cycle.
- grant  out  NPORT  one-hot registered grant, or zero.
- sel  out  3  binary index of the granted port (crossbar select).
- locked  out  1  a packet currently owns the output.
- xfer  out  1  combinational: a flit moves this cycle.
- timeout_err  out  1  one-cycle pulse on watchdog release.

## Operation
- Two states, IDLE and LOCKED, plus a rotating priority pointer ptr (0..NPORT-1).
- Reset (rst=0, asynchronous) sets state=IDLE, ptr=0, grant=0, sel=0, locked=0, timeout_err=0, watchdog count=0.
- IDLE:
  - Eligible ports satisfy req[i]=1 and flit_id[i]=header. Requests carrying body or tail flits are ignored.
  - Choose the first eligible port searching ptr, ptr+1, …, wrapping modulo NPORT.
  - If one is found: grant<=onehot(winner), sel<=winner, state<=LOCKED.
  - If none is found: remain in IDLE with grant=0.
- LOCKED:
  - xfer = |(req & grant) & out_ready.
  - When xfer=1 and the granted port's flit_id is tail: next cycle state=IDLE, grant=0, sel holds its value, ptr=(winner+1) mod NPORT.
  - Single-flit packets are not supported. A header is never also tail.
  - Requests on other ports have no effect while LOCKED.
  - A header seen on the granted port while LOCKED is treated as body.
- locked = (state==LOCKED).
- xfer=0 whenever state is IDLE.
- Simultaneous eligible headers resolve strictly by ptr. With ptr=0, ports win in order L, N, E, W, S.

## Timing
- Arbitration is decided in IDLE cycle t. grant is visible from cycle t+1. The first flit can transfer at t+1.
- The tail transfers in cycle t. grant=0 at t+1. The next arbitration happens in t+1 and its grant appears at t+2. This is one bubble between packets, by design.
- Backpressure: out_ready=0 holds grant, sel and state unchanged indefinitely (non-watchdog build).
- Reset asserted mid-packet clears grant in the same cycle, without waiting for a clock. The next flits are discarded upstream by the router reset.

## Configuration
Macro: ARB_WATCHDOG_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) runs while LOCKED. It is cleared on every xfer and on entry to LOCKED, and increments otherwise.
  - When it reaches TIMEOUT: state<=IDLE, grant<=0, ptr<=winner+1, and timeout_err is high for exactly that following cycle.
  - A tail xfer in the same cycle the count reaches TIMEOUT counts as a normal release, with timeout_err=0.
- Undefined: no counter is built and timeout_err is tied to 0.

## Structure
- Shared package noc_pkg:
  - Port index constants P_L=0, P_N=1, P_E=2, P_W=3, P_S=4.
  - Flit type constants FLIT_HEADER=3'b001, FLIT_BODY=3'b010, FLIT_TAIL=3'b100.
  - The two-state state enum.
- Sub-module rr_pick: combinational rotate-priority picker. Inputs are an eligible vector and ptr; outputs are found, a one-hot winner and a binary index. It is reusable by the other four output-port arbiters.

## Test plan
- Reset: hold rst=0 with random req → grant=0, locked=0, sel=0, timeout_err=0; after release with req=0, stays IDLE.
- Single packet: port N sends header, body, tail with out_ready=1 → grant=5'b00010 one cycle after the header appears, xfer high 3 cycles, grant=0 the cycle after the tail, ptr=2.
- Fairness: all five ports present headers continuously, 2-flit packets → grant sequence L, N, E, W, S, L, one idle cycle between packets.
- Backpressure/lock: E locked, out_ready=0 for 10 cycles while L presents a header → grant stays 5'b00100 and xfer=0. After out_ready=1, E completes before L is granted.
- Watchdog (ARB_WATCHDOG_EN, TIMEOUT=4): W locked, then req[3]=0 → after 4 stall cycles timeout_err pulses 1 cycle, locked=0, next winner searched from S.
- Async reset mid-packet: S locked on a body flit, rst driven low between clock edges → grant=0 immediately; after release, ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, flit types, arbiter states.
// Imported by every output-port arbiter and its interface.
package noc_pkg;

    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_W = 3;
    localparam int P_S = 4;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic is_header(input logic [2:0] f);
        return f == FLIT_HEADER;
    endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// Handshake bundle between input buffers, arbiter and output crossbar.
// master = router side driving requests, slave = arbiter.
interface pkt_rr_arbiter_if #(
    parameter int NPORT = 5
);
    logic [NPORT-1:0]   req;
    logic [3*NPORT-1:0] flit_id;
    logic               out_ready;
    logic [NPORT-1:0]   grant;
    logic [2:0]         sel;
    logic               locked;
    logic               xfer;
    logic               timeout_err;

    modport master (
        output req, flit_id, out_ready,
        input  grant, sel, locked, xfer, timeout_err
    );

    modport slave (
        input  req, flit_id, out_ready,
        output grant, sel, locked, xfer, timeout_err
    );
endinterface

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of elig_i at or after ptr_i,
// wrapping modulo NPORT. Shared by all output-port arbiters.
module rr_pick #(
    parameter int NPORT = 5,
    parameter int PW    = 3
) (
    input  logic [NPORT-1:0] elig_i,
    input  logic [PW-1:0]    ptr_i,
    output logic             found_o,
    output logic [NPORT-1:0] onehot_o,
    output logic [PW-1:0]    idx_o
);
    logic [PW:0] j;

    // Scan ptr, ptr+1, ... and keep the first eligible index.
    always_comb begin
        found_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        j        = '0;
        for (int k = 0; k < NPORT; k++) begin
            j = {1'b0, ptr_i} + (PW+1)'(k);
            if (j >= (PW+1)'(NPORT)) begin
                j = j - (PW+1)'(NPORT);
            end
            if (!found_o && elig_i[j[PW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = j[PW-1:0];
            end
        end
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end
endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-locked round-robin output arbiter for the 5-port NoC router.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module pkt_rr_arbiter
    import noc_pkg::*;
#(
    parameter int NPORT   = 5,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    pkt_rr_arbiter_if.slave  bus
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [0:0] S_IDLE   = ARB_IDLE;
    localparam logic [0:0] S_LOCKED = ARB_LOCKED;

    if (TIMEOUT < 1) begin : g_to_chk
        $error("TIMEOUT must be at least 1");
    end

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [PW-1:0]    win_q, win_d;

    logic [NPORT-1:0] elig;
    logic             found;
    logic [NPORT-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic [2:0]       gflit;
    logic             locked_w;
    logic             xfer_w;
    logic             tail_w;
    logic             wd_fire;
    logic [PW-1:0]    next_ptr;

    // Only header flits may open a new packet.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++) begin
            elig[i] = bus.req[i] && is_header(bus.flit_id[3*i +: 3]);
        end
    end

    rr_pick #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_pick (
        .elig_i   (elig),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx)
    );

    // Flit type presented by the owning port.
    always_comb begin
        gflit = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) begin
                gflit = gflit | bus.flit_id[3*i +: 3];
            end
        end
    end

    assign locked_w = (state_q == S_LOCKED);
    assign xfer_w   = locked_w && (|(bus.req & grant_q))
                      && bus.out_ready;
    assign tail_w   = xfer_w && (gflit == FLIT_TAIL);
    assign next_ptr = (win_q == PW'(NPORT-1)) ? '0
                      : win_q + PW'(1);

`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT+1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    // Fires on the stall cycle that would bring the count to TIMEOUT.
    assign wd_fire = locked_w && !xfer_w
                     && (cnt_q == CW'(TIMEOUT-1));

    // Stall counter: restarts on any transfer and outside LOCKED.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!locked_w || xfer_w || wd_fire) begin
            cnt_d = '0;
        end
    end

    // Watchdog counter and one-cycle release pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= wd_fire;
        end
    end

    assign bus.timeout_err = to_q;
`else
    assign wd_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Arbitrate in IDLE, hold the grant until tail or watchdog.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        win_d   = win_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOCKED;
                    grant_d = pick_oh;
                    win_d   = pick_idx;
                end
            end
            S_LOCKED: begin
                if (tail_w || wd_fire) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbiter state registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            win_q   <= win_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.sel    = 3'(win_q);
    assign bus.locked = locked_w;
    assign bus.xfer   = xfer_w;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Bench for pkt_rr_arbiter: directed scenarios plus random traffic
// against a packet-level reference model. Honours ARB_WATCHDOG_EN.
module tb_pkt_rr_arbiter;
    import noc_pkg::*;

    localparam int N  = 5;
    localparam int TO = 4;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_rr_arbiter_if #(.NPORT(N)) bus();

    pkt_rr_arbiter #(
        .NPORT   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 = none), rotation pointer, stall count.
    int m_own;
    int m_ptr;
    int m_sel;
    int m_cnt;
    bit m_err;
    bit exp_x;
    bit obs_x;

    function automatic logic [2:0] fid(int p);
        return bus.flit_id[3*p +: 3];
    endfunction

    function automatic logic [4:0] m_grant();
        logic [4:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    task automatic setf(int p, logic [2:0] f);
        bus.req[p] = 1'b1;
        bus.flit_id[3*p +: 3] = f;
    endtask

    task automatic clear_all();
        bus.req = '0;
        bus.flit_id = '0;
    endtask

    task automatic model_reset();
        m_own = -1;
        m_ptr = 0;
        m_sel = 0;
        m_cnt = 0;
        m_err = 0;
    endtask

    task automatic model_clock();
        bit x;
        bit done;
        m_err = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_own < 0) begin
            done = 0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!done && bus.req[j] && fid(j) == FLIT_HEADER) begin
                    m_own = j;
                    m_sel = j;
                    m_cnt = 0;
                    done = 1;
                end
            end
        end else begin
            x = bus.req[m_own] && bus.out_ready;
            if (x && fid(m_own) == FLIT_TAIL) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else if (x) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (WD && m_cnt == TO) begin
                    m_ptr = (m_own + 1) % N;
                    m_own = -1;
                    m_err = 1;
                end
            end
        end
    endtask

    // One clock: sample xfer mid-cycle, update model at the edge.
    task automatic tick();
        #1;
        exp_x = (m_own >= 0) && bus.req[m_own] && bus.out_ready;
        obs_x = bus.xfer;
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.flit_id = {N{FLIT_HEADER}};
        model_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req = N'($urandom);
            tick();
            checks++;
            if (bus.grant !== 5'b0 || bus.locked !== 1'b0
                || bus.sel !== 3'd0 || bus.timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: grant=%b locked=%b sel=%0d err=%b want 0",
                         bus.grant, bus.locked, bus.sel, bus.timeout_err);
            end
        end
        clear_all();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.locked !== 1'b0 || bus.grant !== 5'b0 || obs_x !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: locked=%b grant=%b xfer=%b want 0",
                         bus.locked, bus.grant, obs_x);
            end
        end
    endtask

    task automatic test_single_packet();
        logic [2:0] seq [3];
        seq[0] = FLIT_HEADER;
        seq[1] = FLIT_BODY;
        seq[2] = FLIT_TAIL;
        setf(P_N, FLIT_HEADER);
        tick();
        checks++;
        if (bus.grant !== 5'b00010 || bus.sel !== 3'd1 || obs_x !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: grant=%b sel=%0d xfer=%b want 00010 1 0",
                     bus.grant, bus.sel, obs_x);
        end
        for (int f = 0; f < 3; f++) begin
            setf(P_N, seq[f]);
            tick();
            checks++;
            if (obs_x !== 1'b1) begin
                errors++;
                $display("FAIL single_xfer%0d: xfer=%b want 1", f, obs_x);
            end
        end
        checks++;
        if (bus.grant !== 5'b0 || bus.locked !== 1'b0 || bus.sel !== 3'd1) begin
            errors++;
            $display("FAIL single_release: grant=%b locked=%b sel=%0d want 0 0 1",
                     bus.grant, bus.locked, bus.sel);
        end
        clear_all();
        setf(P_L, FLIT_HEADER);
        setf(P_E, FLIT_HEADER);
        tick();
        checks++;
        if (bus.grant !== 5'b00100) begin
            errors++;
            $display("FAIL single_ptr: grant=%b want 00100", bus.grant);
        end
        tick();
        setf(P_E, FLIT_TAIL);
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_fairness();
        int order [6] = '{0, 1, 2, 3, 4, 0};
        logic [4:0] want;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req = '1;
        bus.flit_id = {N{FLIT_HEADER}};
        for (int p = 0; p < 6; p++) begin
            want = '0;
            want[order[p]] = 1'b1;
            tick();
            checks++;
            if (bus.grant !== want || bus.grant !== m_grant()) begin
                errors++;
                $display("FAIL fair_grant%0d: grant=%b want %b", p, bus.grant, want);
            end
            tick();
            setf(order[p], FLIT_TAIL);
            tick();
            checks++;
            if (obs_x !== 1'b1 || bus.grant !== 5'b0) begin
                errors++;
                $display("FAIL fair_bubble%0d: xfer=%b grant=%b want 1 00000",
                         p, obs_x, bus.grant);
            end
            setf(order[p], FLIT_HEADER);
        end
        clear_all();
        tick();
    endtask

    task automatic test_backpressure();
        int stalls;
        stalls = WD ? TO - 1 : 10;
        setf(P_E, FLIT_HEADER);
        tick();
        bus.out_ready = 1'b0;
        setf(P_L, FLIT_HEADER);
        for (int i = 0; i < stalls; i++) begin
            tick();
            checks++;
            if (bus.grant !== 5'b00100 || obs_x !== 1'b0 || bus.sel !== 3'd2) begin
                errors++;
                $display("FAIL bp_hold%0d: grant=%b xfer=%b sel=%0d want 00100 0 2",
                         i, bus.grant, obs_x, bus.sel);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        setf(P_E, FLIT_TAIL);
        tick();
        checks++;
        if (obs_x !== 1'b1 || bus.grant !== 5'b0) begin
            errors++;
            $display("FAIL bp_finish: xfer=%b grant=%b want 1 00000", obs_x, bus.grant);
        end
        bus.req[P_E] = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 5'b00001) begin
            errors++;
            $display("FAIL bp_next: grant=%b want 00001", bus.grant);
        end
        tick();
        setf(P_L, FLIT_TAIL);
        tick();
        clear_all();
    endtask

    task automatic test_async_reset();
        setf(P_S, FLIT_HEADER);
        tick();
        tick();
        setf(P_S, FLIT_BODY);
        tick();
        checks++;
        if (bus.grant !== 5'b10000) begin
            errors++;
            $display("FAIL ar_lock: grant=%b want 10000", bus.grant);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 5'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL ar_async: grant=%b locked=%b want 0 0",
                     bus.grant, bus.locked);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_all();
        setf(P_L, FLIT_HEADER);
        setf(P_N, FLIT_HEADER);
        tick();
        checks++;
        if (bus.grant !== 5'b00001) begin
            errors++;
            $display("FAIL ar_ptr: grant=%b want 00001", bus.grant);
        end
        tick();
        setf(P_L, FLIT_TAIL);
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_watchdog();
        setf(P_W, FLIT_HEADER);
        tick();
        checks++;
        if (bus.grant !== 5'b01000) begin
            errors++;
            $display("FAIL wd_lock: grant=%b want 01000", bus.grant);
        end
        bus.req[P_W] = 1'b0;
        setf(P_L, FLIT_HEADER);
        setf(P_S, FLIT_HEADER);
        for (int i = 0; i < TO; i++) begin
            tick();
            if (i < TO - 1) begin
                checks++;
                if (bus.locked !== 1'b1 || bus.timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_wait%0d: locked=%b err=%b want 1 0",
                             i, bus.locked, bus.timeout_err);
                end
            end
        end
        checks++;
        if (bus.timeout_err !== WD || bus.locked !== !WD) begin
            errors++;
            $display("FAIL wd_fire: err=%b locked=%b want %b %b",
                     bus.timeout_err, bus.locked, WD, !WD);
        end
        if (WD) begin
            tick();
            checks++;
            if (bus.timeout_err !== 1'b0 || bus.grant !== 5'b10000) begin
                errors++;
                $display("FAIL wd_after: err=%b grant=%b want 0 10000",
                         bus.timeout_err, bus.grant);
            end
            tick();
            setf(P_S, FLIT_TAIL);
            tick();
        end else begin
            setf(P_W, FLIT_TAIL);
            tick();
        end
        clear_all();
        tick();
    endtask

    task automatic test_random();
        int pos [N];
        int len [N];
        int prev;
        bit prev_tail;
        for (int p = 0; p < N; p++) begin
            pos[p] = 0;
            len[p] = 2 + int'($urandom_range(3));
        end
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                logic [2:0] f;
                if (p == m_own) begin
                    bus.req[p] = ($urandom_range(3) != 0);
                    if (pos[p] == len[p] - 1) f = FLIT_TAIL;
                    else if (pos[p] == 0) f = FLIT_HEADER;
                    else if ($urandom_range(7) == 0) f = FLIT_HEADER;
                    else f = FLIT_BODY;
                end else begin
                    pos[p] = 0;
                    bus.req[p] = $urandom_range(1) != 0;
                    if ($urandom_range(4) != 0) f = FLIT_HEADER;
                    else if ($urandom_range(1) != 0) f = FLIT_BODY;
                    else f = FLIT_TAIL;
                end
                bus.flit_id[3*p +: 3] = f;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            prev = m_own;
            prev_tail = (prev >= 0) && (fid(prev) == FLIT_TAIL);
            tick();
            checks++;
            if (obs_x !== exp_x || bus.grant !== m_grant()
                || bus.sel !== 3'(m_sel) || bus.locked !== (m_own >= 0)
                || bus.timeout_err !== m_err) begin
                errors++;
                $display("FAIL rand%0d: x=%b g=%b s=%0d l=%b e=%b want %b %b %0d %b %b",
                         c, obs_x, bus.grant, bus.sel, bus.locked,
                         bus.timeout_err, exp_x, m_grant(), m_sel,
                         m_own >= 0, m_err);
            end
            if (prev >= 0 && exp_x) begin
                if (prev_tail) begin
                    pos[prev] = 0;
                    len[prev] = 2 + int'($urandom_range(3));
                end else begin
                    pos[prev]++;
                end
            end
        end
        clear_all();
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        clear_all();
        bus.out_ready = 1'b1;
        rst = 1'b0;
        model_reset();
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_async_reset();
        test_watchdog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
